// File: rtl/mem_pkg.sv
// Shared FSM state encoding and memory bus direction constants for mem_master.
// INIT exists only when MEM_MASTER_INIT_EN is defined.
package mem_pkg;

`ifdef MEM_MASTER_INIT_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, INIT} mem_state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN} mem_state_t;
`endif

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

endpackage

// File: rtl/mem_master.sv
// Burst master for a simple synchronous SRAM: write/read bursts of up to 16 beats.
// Define MEM_MASTER_INIT_EN to zero-fill the whole memory after reset before accepting requests.
//
// Handshakes: a transfer on req_* or wr_* happens on a rising edge where valid and ready
// are both high; rd_valid is a one-cycle strobe with no backpressure.
module mem_master
  import mem_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int MEM_SIZE = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              init_done,
  output logic              mem_cs,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        fsm_state
);

  mem_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [3:0]        beats_left;
  logic              rd_pend;

  assign addr_inc  = (addr == ADDR_W'(MEM_SIZE - 1)) ? '0 : addr + 1'b1;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

`ifdef MEM_MASTER_INIT_EN
  logic init_done_r;
  assign init_done = init_done_r;
`else
  assign init_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef MEM_MASTER_INIT_EN
      state       <= INIT;
      init_done_r <= 1'b0;
`else
      state       <= IDLE;
`endif
      addr       <= '0;
      beats_left <= '0;
      rd_pend    <= 1'b0;
      mem_cs     <= 1'b0;
      mem_rw     <= MEM_READ;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      wr_ready   <= 1'b0;
      req_ready  <= 1'b0;
    end else begin
      // Read return pipe: issue cycle -> rdata valid next cycle -> rd_valid the cycle after.
      rd_pend  <= mem_cs && (mem_rw == MEM_READ);
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= mem_rdata;
      mem_cs <= 1'b0;

      case (state)
        IDLE: begin
          req_ready <= init_done;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            addr       <= req_addr;
            beats_left <= req_len;
            if (req_write) begin
              state    <= WRITE;
              wr_ready <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end

        WRITE: begin
          if (!wr_ready) begin
            // Final beat has been on the bus for one cycle.
            state     <= IDLE;
            req_ready <= init_done;
          end else if (wr_valid) begin
            mem_cs     <= 1'b1;
            mem_rw     <= MEM_WRITE;
            mem_addr   <= addr;
            mem_wdata  <= wr_data;
            addr       <= addr_inc;
            beats_left <= beats_left - 4'd1;
            if (beats_left == 4'd0) wr_ready <= 1'b0;
          end
        end

        READ: begin
          mem_cs     <= 1'b1;
          mem_rw     <= MEM_READ;
          mem_addr   <= addr;
          addr       <= addr_inc;
          beats_left <= beats_left - 4'd1;
          if (beats_left == 4'd0) state <= DRAIN;
        end

        DRAIN: begin
          if (!mem_cs && !rd_pend) begin
            state     <= IDLE;
            req_ready <= init_done;
          end
        end

`ifdef MEM_MASTER_INIT_EN
        INIT: begin
          if (mem_cs && mem_addr == ADDR_W'(MEM_SIZE - 1)) begin
            state       <= IDLE;
            init_done_r <= 1'b1;
            req_ready   <= 1'b1;
          end else begin
            mem_cs    <= 1'b1;
            mem_rw    <= MEM_WRITE;
            mem_addr  <= addr;
            mem_wdata <= '0;
            addr      <= addr_inc;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: bus transactions and read data are checked against
// expected queues filled by the stimulus; cycle-timing checks live in the driver tasks.
module tb_mem_master;
  import mem_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy, init_done;
  logic       mem_cs, mem_rw;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0] fsm_state;

`ifdef MEM_MASTER_INIT_EN
  localparam logic INIT_EN = 1'b1;
`else
  localparam logic INIT_EN = 1'b0;
`endif

  mem_master #(.DATA_W(8), .ADDR_W(8), .MEM_SIZE(256)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .init_done(init_done),
    .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [7:0] mem_model [256];
  always @(posedge clk) begin
    if (mem_cs === 1'b1) begin
      if (mem_rw) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [16:0] exp_mem_q[$];   // {rw, addr, wdata (0 for reads)}
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  wbuf [16];
  logic [16:0] mon_mem_e;
  logic [7:0]  mon_rd_e;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mem_cs === 1'b1) begin
      if (exp_mem_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_unexpected: got rw=%0d addr=0x%0h data=0x%0h, nothing expected (cycle %0d)",
                 mem_rw, mem_addr, mem_wdata, cyc);
      end else begin
        mon_mem_e = exp_mem_q.pop_front();
        check("mem_txn", {15'd0, mem_rw, mem_addr, (mem_rw ? mem_wdata : 8'h00)}, {15'd0, mon_mem_e});
      end
    end
    if (rd_valid === 1'b1) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got 0x%0h, nothing expected (cycle %0d)", rd_data, cyc);
      end else begin
        mon_rd_e = exp_rd_q.pop_front();
        check("rd_data", {24'd0, rd_data}, {24'd0, mon_rd_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_init_expect();
    for (int i = 0; i < 256; i++) begin
      exp_mem_q.push_back({1'b1, 8'(i), 8'h00});
      ref_mem[i] = 8'h00;
    end
  endtask

  task automatic wait_init();
    int t = 0;
    while (!init_done && t < 400) begin
      check("ready_low_during_init", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      t++;
    end
    check("init_done_rise", {31'd0, init_done}, 32'd1);
    check("init_all_written", exp_mem_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {3'd0, mem_cs, mem_rw, mem_addr, mem_wdata, rd_valid, rd_data, wr_ready, req_ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, {31'd0, INIT_EN});
    check("reset_init_done", {31'd0, init_done}, {31'd0, ~INIT_EN});
    check("reset_state", {29'd0, fsm_state}, INIT_EN ? 32'd4 : 32'd0);
    if (INIT_EN) push_init_expect();
    reset = 1'b0;
    if (INIT_EN) wait_init();
  endtask

  task automatic wait_req_ready();
    int t = 0;
    while (!req_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("req_ready_seen", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic issue_req(input logic wr, input logic [7:0] addr, input logic [3:0] len);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [7:0] addr, input logic [3:0] len, input int gap_at, input int gap_len);
    int t;
    wait_req_ready();
    for (int i = 0; i <= int'(len); i++) begin
      exp_mem_q.push_back({1'b1, addr + 8'(i), wbuf[i]});
      ref_mem[addr + 8'(i)] = wbuf[i];
    end
    issue_req(1'b1, addr, len);
    check("wr_accepted", {30'd0, busy, wr_ready}, 32'd3);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == gap_at) begin
        wr_valid = 1'b0;
        repeat (gap_len) begin
          @(posedge clk); #1;
          check("gap_cs_low", {31'd0, mem_cs}, 32'd0);
        end
      end
      wr_valid = 1'b1;
      wr_data  = wbuf[i];
      t = 0;
      while (!wr_ready && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      @(posedge clk); #1;
      check("wr_beat_on_bus", {30'd0, mem_cs, mem_rw}, 32'd3);
    end
    wr_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_after_write", {30'd0, busy, req_ready}, 32'd1);
  endtask

  task automatic read_burst(input logic [7:0] addr, input logic [3:0] len);
    int t;
    int c0;
    int c1;
    wait_req_ready();
    for (int i = 0; i <= int'(len); i++) begin
      exp_mem_q.push_back({1'b0, addr + 8'(i), 8'h00});
      exp_rd_q.push_back(ref_mem[addr + 8'(i)]);
    end
    issue_req(1'b0, addr, len);
    t = 0;
    while (!mem_cs && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("rd_issue_seen", {31'd0, mem_cs}, 32'd1);
    c0 = cyc;
    t = 0;
    while (!rd_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    c1 = cyc;
    check("rd_latency", c1 - c0, 32'd2);
    for (int i = 1; i <= int'(len); i++) begin
      @(posedge clk); #1;
      check("rd_consecutive", {31'd0, rd_valid}, 32'd1);
    end
    t = 0;
    while (busy && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("idle_after_read", {30'd0, busy, rd_valid}, 32'd0);
  endtask

  task automatic reset_mid_read();
    wait_req_ready();
    exp_mem_q.push_back({1'b0, 8'h20, 8'h00});
    issue_req(1'b0, 8'h20, 4'd7);
    @(posedge clk); #1;
    check("rd_issue_before_reset", {22'd0, mem_cs, mem_rw, mem_addr}, {22'd0, 1'b1, 1'b0, 8'h20});
    reset = 1'b1;
    @(posedge clk); #1;
    check("cs_low_after_reset", {30'd0, mem_cs, rd_valid}, 32'd0);
    if (INIT_EN) push_init_expect();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("no_rd_after_reset", {31'd0, rd_valid}, 32'd0);
    end
    if (INIT_EN) wait_init();
    wait_req_ready();
    check("idle_after_reset", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    do_reset();

    // wr_valid in IDLE must not reach the memory
    wait_req_ready();
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_wr_ignored", {29'd0, mem_cs, wr_ready, busy}, 32'd0);
    end
    wr_valid = 1'b0;

    wbuf[0] = 8'hA1; wbuf[1] = 8'hA2; wbuf[2] = 8'hA3; wbuf[3] = 8'hA4;
    write_burst(8'h10, 4'd3, -1, 0);
    read_burst(8'h10, 4'd3);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    write_burst(8'hFE, 4'd2, -1, 0);
    read_burst(8'hFF, 4'd1);

    wbuf[0] = 8'h5C; wbuf[1] = 8'hC5;
    write_burst(8'h00, 4'd1, 1, 2);
    read_burst(8'h00, 4'd1);

    reset_mid_read();

    repeat (5) @(posedge clk);
    #1;
    check("mem_q_drained", exp_mem_q.size(), 32'd0);
    check("rd_q_drained", exp_rd_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got no completion, required finish before %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
